// File: rtl/phasenoisepon_nibble_sequencer_pkg.sv
// Shared types and constants for the nibble sequencer and its arbiter.
package phasenoisepon_nibble_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_LO,
    ST_HI,
    ST_CALC,
    ST_CAP,
    ST_RESP
  } seq_state_t;

  localparam logic [1:0] CTL_LOAD_LO = 2'b00;
  localparam logic [1:0] CTL_LOAD_HI = 2'b01;
  localparam logic [1:0] CTL_CALC    = 2'b10;

  localparam logic [7:0] ECHO_LO = 8'h0F;
  localparam logic [7:0] ECHO_HI = 8'hF0;

endpackage

// File: rtl/phasenoisepon_rr_arb2.sv
// Two-way round-robin arbiter; grants only while en is high.
module phasenoisepon_rr_arb2 #(
  parameter bit RR_INIT = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b
);

  logic prefer_b_q;

  // Single request wins outright; contention goes to the side not granted last.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (en) begin
      if (req_a && req_b) begin
        gnt_a = ~prefer_b_q;
        gnt_b = prefer_b_q;
      end else begin
        gnt_a = req_a;
        gnt_b = req_b;
      end
    end
  end

  // Pointer moves only when a grant is issued.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prefer_b_q <= RR_INIT;
    end else if (gnt_a) begin
      prefer_b_q <= 1'b1;
    end else if (gnt_b) begin
      prefer_b_q <= 1'b0;
    end
  end

endmodule

// File: rtl/phasenoisepon_nibble_sequencer.sv
// Round-robin sequencer feeding bytes as two nibbles into the nibble-loader
// datapath, then returning the captured result on a valid/ready port.
// Optional echo checking: define PHASENOISEPON_SEQ_CHECK_EN.
module phasenoisepon_nibble_sequencer
  import phasenoisepon_nibble_sequencer_pkg::*;
#(
  parameter int unsigned CALC_CYCLES = 1,
  parameter bit          RR_INIT     = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req_a_valid,
  input  logic [7:0] req_a_data,
  output logic       req_a_ready,
  input  logic       req_b_valid,
  input  logic [7:0] req_b_data,
  output logic       req_b_ready,
  output logic       dp_reset,
  output logic [1:0] dp_ctl,
  output logic [3:0] dp_data,
  input  logic [7:0] dp_out,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_id,
  input  logic       rsp_ready,
  output logic       busy,
  output logic       err
);

  localparam logic [3:0] CALC_LAST = 4'(CALC_CYCLES - 1);

  seq_state_t state_q, state_d;
  logic [7:0] byte_q;
  logic       id_q;
  logic [7:0] rsp_data_q;
  logic [3:0] calc_cnt_q;
  logic       gnt_a, gnt_b;

  phasenoisepon_rr_arb2 #(.RR_INIT(RR_INIT)) u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (state_q == ST_IDLE),
    .req_a   (req_a_valid),
    .req_b   (req_b_valid),
    .gnt_a   (gnt_a),
    .gnt_b   (gnt_b)
  );

  assign req_a_ready = gnt_a;
  assign req_b_ready = gnt_b;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT: state_d = ST_IDLE;
      ST_IDLE: if (gnt_a || gnt_b) state_d = ST_LO;
      ST_LO:   state_d = ST_HI;
      ST_HI:   state_d = ST_CALC;
      ST_CALC: if (calc_cnt_q == CALC_LAST) state_d = ST_CAP;
      ST_CAP:  state_d = ST_RESP;
      ST_RESP: if (rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_INIT;
    endcase
  end

  // Moore output decode; idle and wait states hold ctl at calc so stored nibbles survive.
  always_comb begin
    dp_reset  = 1'b0;
    dp_ctl    = CTL_CALC;
    dp_data   = '0;
    busy      = 1'b1;
    rsp_valid = 1'b0;
    case (state_q)
      ST_INIT: dp_reset = 1'b1;
      ST_IDLE: busy = 1'b0;
      ST_LO: begin
        dp_ctl  = CTL_LOAD_LO;
        dp_data = byte_q[3:0];
      end
      ST_HI: begin
        dp_ctl  = CTL_LOAD_HI;
        dp_data = byte_q[7:4];
      end
      ST_RESP: rsp_valid = 1'b1;
      default: ;
    endcase
  end

  assign rsp_data = rsp_data_q;
  assign rsp_id   = id_q;

  // Latch the granted byte/source, run the calc counter, capture the result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      byte_q     <= '0;
      id_q       <= 1'b0;
      rsp_data_q <= '0;
      calc_cnt_q <= '0;
    end else begin
      if (gnt_a || gnt_b) begin
        byte_q <= gnt_b ? req_b_data : req_a_data;
        id_q   <= gnt_b;
      end
      if (state_q == ST_CALC) begin
        calc_cnt_q <= calc_cnt_q + 4'd1;
      end else begin
        calc_cnt_q <= '0;
      end
      if (state_q == ST_CAP) begin
        rsp_data_q <= dp_out;
      end
    end
  end

`ifdef PHASENOISEPON_SEQ_CHECK_EN
  logic err_q;

  // Sticky flag on a bad load echo in HI or in the first CALC cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else if (((state_q == ST_HI) && (dp_out != ECHO_LO)) ||
                 ((state_q == ST_CALC) && (calc_cnt_q == '0) && (dp_out != ECHO_HI))) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
